// File: rtl/cic_pkg.sv
// Shared constants, width helpers and FSM encoding for the CIC decimator and
// the downstream halfband stages.
package cic_pkg;

    localparam int DEFAULT_DECIM    = 32;
    localparam int DEFAULT_N_STAGES = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        COMB    = 2'd2,
        EMIT    = 2'd3
    } cic_state_e;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    // Bit growth of an N-stage CIC is N*log2(R*M); one extra bit holds full scale.
    function automatic int acc_width(input int n_stages, input int decim, input int diff_delay);
        return 1 + n_stages * clog2(decim * diff_delay);
    endfunction

endpackage

// File: rtl/cic_integrator.sv
// One enable-gated integrator of the CIC chain; wraps modulo 2^W by design.
module cic_integrator #(
    parameter int W = 21
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] acc
);

    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (en) begin
            acc_d = acc_q + din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/pdm_cic_decimator.sv
// PDM-to-PCM CIC decimator: strobe-qualified integrators plus a single
// time-multiplexed comb. Define CIC_SAT_EN to clamp full scale instead of wrapping.
module pdm_cic_decimator
    import cic_pkg::*;
#(
    parameter int N_STAGES   = DEFAULT_N_STAGES,
    parameter int DECIM      = DEFAULT_DECIM,
    parameter int DIFF_DELAY = 1,
    parameter int OUT_W      = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pdm_en,
    input  logic             pdm_in,
    output logic [OUT_W-1:0] pcm_out,
    output logic             pcm_valid,
    output logic             overrun
);

    localparam int ACC_W = acc_width(N_STAGES, DECIM, DIFF_DELAY);
    localparam int DEC_W = clog2(DECIM);
    localparam int STG_W = (clog2(N_STAGES) > 0) ? clog2(N_STAGES) : 1;
    localparam int WRM_W = clog2(N_STAGES + 1);
    localparam int SHIFT = ACC_W - 1 - OUT_W;
    localparam int PAD   = (SHIFT < 0) ? -SHIFT : 1;
`ifdef CIC_SAT_EN
    localparam logic SAT_ON = 1'b1;
`else
    localparam logic SAT_ON = 1'b0;
`endif

    logic [ACC_W-1:0] integ [N_STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < N_STAGES; gi++) begin : g_integ
            logic [ACC_W-1:0] din;
            if (gi == 0) begin : g_first
                assign din = {{(ACC_W-1){1'b0}}, pdm_in};
            end else begin : g_rest
                assign din = integ[gi-1];
            end
            cic_integrator #(.W(ACC_W)) u_integ (
                .clk (clk),
                .rst (rst),
                .en  (pdm_en),
                .din (din),
                .acc (integ[gi])
            );
        end
    endgenerate

    cic_state_e       state_q, state_d;
    logic [DEC_W-1:0] dec_q, dec_d;
    logic [STG_W-1:0] stg_q, stg_d;
    logic [WRM_W-1:0] warm_q, warm_d;
    logic [ACC_W-1:0] comb_q, comb_d;
    logic [ACC_W-1:0] dly_q [N_STAGES][DIFF_DELAY];
    logic [ACC_W-1:0] dly_d [N_STAGES][DIFF_DELAY];
    logic [OUT_W-1:0] pcm_out_q, pcm_out_d;
    logic             pcm_valid_q, pcm_valid_d;
    logic             overrun_q, overrun_d;

    logic             tick;
    logic [OUT_W:0]   scaled;
    logic             sat_hit;
    logic [OUT_W-1:0] pcm_next;

    assign tick = pdm_en && (dec_q == DEC_W'(DECIM - 1));

    // Keep the OUT_W bits just below the wrap bit, plus the overflow bit above them.
    generate
        if (SHIFT >= 0) begin : g_shr
            assign scaled = comb_q[SHIFT +: OUT_W+1];
        end else begin : g_shl
            assign scaled = {comb_q, {PAD{1'b0}}};
        end
    endgenerate

    assign sat_hit  = scaled[OUT_W] & SAT_ON;
    assign pcm_next = scaled[OUT_W-1:0] | {OUT_W{sat_hit}};

    always_comb begin
        state_d     = state_q;
        dec_d       = dec_q;
        stg_d       = stg_q;
        warm_d      = warm_q;
        comb_d      = comb_q;
        dly_d       = dly_q;
        pcm_out_d   = pcm_out_q;
        pcm_valid_d = 1'b0;
        overrun_d   = overrun_q;

        if (pdm_en) begin
            dec_d = tick ? '0 : dec_q + DEC_W'(1);
        end
        if (tick && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                comb_d  = integ[N_STAGES-1];
                stg_d   = '0;
                state_d = COMB;
            end
            COMB: begin
                comb_d = comb_q - dly_q[stg_q][DIFF_DELAY-1];
                dly_d[stg_q][0] = comb_q;
                for (int i = 1; i < DIFF_DELAY; i++) begin
                    dly_d[stg_q][i] = dly_q[stg_q][i-1];
                end
                if (stg_q == STG_W'(N_STAGES - 1)) begin
                    state_d = EMIT;
                end else begin
                    stg_d = stg_q + STG_W'(1);
                end
            end
            EMIT: begin
                pcm_out_d = pcm_next;
                // Early results are computed to prime the comb delays but not announced.
                if (warm_q == WRM_W'(N_STAGES)) begin
                    pcm_valid_d = 1'b1;
                end else begin
                    warm_d = warm_q + WRM_W'(1);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            dec_q       <= '0;
            stg_q       <= '0;
            warm_q      <= '0;
            comb_q      <= '0;
            pcm_out_q   <= '0;
            pcm_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int k = 0; k < N_STAGES; k++) begin
                for (int j = 0; j < DIFF_DELAY; j++) begin
                    dly_q[k][j] <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            dec_q       <= dec_d;
            stg_q       <= stg_d;
            warm_q      <= warm_d;
            comb_q      <= comb_d;
            pcm_out_q   <= pcm_out_d;
            pcm_valid_q <= pcm_valid_d;
            overrun_q   <= overrun_d;
            dly_q       <= dly_d;
        end
    end

    assign pcm_out   = pcm_out_q;
    assign pcm_valid = pcm_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Directed bench for pdm_cic_decimator: default instance plus a DECIM=2 instance
// that is deliberately driven faster than its comb can keep up.
module tb_pdm_cic_decimator;

    localparam int DECIM = 32;
`ifdef CIC_SAT_EN
    localparam logic [16:0] FS_EXP = 17'h1FFFF;
`else
    localparam logic [16:0] FS_EXP = 17'h00000;
`endif
    localparam logic [16:0] HALF_EXP = 17'h10000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pdm_en = 1'b0;
    logic        pdm_in = 1'b0;
    logic        pdm_en2 = 1'b0;
    logic        pdm_in2 = 1'b0;
    logic [16:0] pcm_out, pcm_out2;
    logic        pcm_valid, pcm_valid2;
    logic        overrun, overrun2;

    int          tests = 0;
    int          fails = 0;
    int          edge_n = 0;
    int          en_total = 0;
    int          last_tick_edge = 0;
    int          valid_cnt = 0;
    int          valid2_cnt = 0;
    int          last_valid_edge = 0;
    int          prev_valid_edge = 0;
    logic [16:0] last_out = '0;
    logic        alt_bit = 1'b1;
    int          snap;

    always #5 clk = ~clk;

    pdm_cic_decimator dut (
        .clk       (clk),
        .rst       (rst),
        .pdm_en    (pdm_en),
        .pdm_in    (pdm_in),
        .pcm_out   (pcm_out),
        .pcm_valid (pcm_valid),
        .overrun   (overrun)
    );

    pdm_cic_decimator #(.DECIM(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .pdm_en    (pdm_en2),
        .pdm_in    (pdm_in2),
        .pcm_out   (pcm_out2),
        .pcm_valid (pcm_valid2),
        .overrun   (overrun2)
    );

    always @(posedge clk) edge_n++;

    always @(posedge clk) begin
        #1;
        if (pcm_valid) begin
            valid_cnt++;
            prev_valid_edge = last_valid_edge;
            last_valid_edge = edge_n;
            last_out = pcm_out;
            $display("[TB] edge %0d pcm_valid pcm_out=%05h", edge_n, pcm_out);
        end
        if (pcm_valid2) valid2_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: zeros, 1: ones, 2: alternating; one pdm_en strobe every 'period' clocks
    task automatic feed(input int nbits, input int period, input int mode);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            pdm_en = 1'b1;
            case (mode)
                0: pdm_in = 1'b0;
                1: pdm_in = 1'b1;
                default: begin
                    pdm_in = alt_bit;
                    alt_bit = ~alt_bit;
                end
            endcase
            if ((en_total % DECIM) == DECIM - 1) last_tick_edge = edge_n + 1;
            en_total++;
            for (int p = 1; p < period; p++) begin
                @(negedge clk);
                pdm_en = 1'b0;
            end
        end
        @(negedge clk);
        pdm_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pdm_en = 1'b0;
            pdm_in = 1'b1;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_pcm_out", pcm_out, 0);
        check("rst_pcm_valid", pcm_valid, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        en_total = 0;

        // all-ones, one strobe every 4 clocks
        feed(128, 4, 1);
        idle(10);
        check("warmup_no_valid", valid_cnt, 0);
        feed(96, 4, 1);
        idle(10);
        check("ones_valid_cnt", valid_cnt, 3);
        check("ones_pcm_out", last_out, FS_EXP);
        check("ones_interval", last_valid_edge - prev_valid_edge, 128);
        check("ones_overrun", overrun, 0);

        // alternating, strobe every clock
        snap = valid_cnt;
        feed(256, 1, 2);
        idle(10);
        check("alt_valid_cnt", valid_cnt, snap + 8);
        check("alt_pcm_out", last_out, HALF_EXP);
        check("alt_latency", last_valid_edge - last_tick_edge, 6);

        feed(192, 1, 0);
        idle(10);
        check("zeros_pcm_out", last_out, 0);

        // long pdm_en gap mid-stream
        feed(192, 1, 2);
        idle(10);
        snap = valid_cnt;
        idle(500);
        check("hold_no_valid", valid_cnt, snap);
        check("hold_pcm_out", pcm_out, HALF_EXP);
        feed(64, 1, 2);
        idle(10);
        check("resume_valid_cnt", valid_cnt, snap + 2);
        check("resume_pcm_out", last_out, HALF_EXP);

        // reset during the comb sequence of an in-flight sample
        feed(32, 1, 2);
        repeat (2) @(negedge clk);
        snap = valid_cnt;
        rst = 1'b1;
        en_total = 0;
        #1;
        check("midrst_pcm_out", pcm_out, 0);
        check("midrst_pcm_valid", pcm_valid, 0);
        check("midrst_overrun", overrun, 0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        idle(10);
        check("midrst_no_valid", valid_cnt, snap);
        feed(128, 1, 1);
        idle(10);
        check("rewarm_no_valid", valid_cnt, snap);
        feed(32, 1, 1);
        idle(10);
        check("rewarm_valid_cnt", valid_cnt, snap + 1);
        check("rewarm_pcm_out", last_out, FS_EXP);

        // DECIM=2 instance: ticks every 2 clocks, comb busy for 6
        @(negedge clk);
        pdm_en2 = 1'b1;
        pdm_in2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("d2_first_tick_ovr", overrun2, 0);
        repeat (2) @(posedge clk);
        #1;
        check("d2_busy_tick_ovr", overrun2, 1);
        repeat (60) @(posedge clk);
        #1;
        check("d2_valid_seen", (valid2_cnt > 0), 1);
        check("d2_pcm_out", pcm_out2, 0);
        check("d2_ovr_sticky", overrun2, 1);
        check("d1_ovr_clear", overrun, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
